wbuf_ram: RTL and testbench
===========================

WBUF_RAM -- requirements
Module: wbuf_ram

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9, address bits per port; depth = 2^ADDR_WIDTH words.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, bits per word.
REQ-003 SHALL have parameter OUTPUT_REG, default 1, 0/1; 1 adds one output pipeline register.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port s_write_req  input  1  write enable.
REQ-007 SHALL have port s_write_addr  input  ADDR_WIDTH  write address.
REQ-008 SHALL have port s_write_data  input  DATA_WIDTH  write data.
REQ-009 SHALL have port s_read_req  input  1  read enable.
REQ-010 SHALL have port s_read_addr  input  ADDR_WIDTH  read address.
REQ-011 SHALL have port s_read_data  output  DATA_WIDTH  read data.

Function
REQ-012 SHALL write s_write_data to mem[s_write_addr] on a clk edge with s_write_req=1; no write otherwise.
REQ-013 SHALL capture mem[s_read_addr] into an internal read register on a clk edge with s_read_req=1; hold the register when s_read_req=0.
REQ-014 SHALL present read data one cycle after the request when OUTPUT_REG=0, two cycles after when OUTPUT_REG=1.
REQ-015 SHALL, with OUTPUT_REG=1, load the output register from the read register every cycle (free-running, no enable).
REQ-016 SHALL allow a read and a write in the same cycle to any addresses, with no stall and no handshake.
REQ-017 SHALL, on same-cycle read and write to the same address without the bypass feature, return the old contents (read-first).
REQ-018 SHALL take all address bits as-is; no wrap or range check is needed since every encoding is valid.

Reset
REQ-019 SHALL clear the read register and the output register to 0 when reset=1 at a clk edge; s_read_data=0 from the next cycle.
REQ-020 SHALL NOT clear memory contents on reset; words written before reset stay readable after it.
REQ-021 SHALL give reset priority over a concurrent s_read_req in the same cycle; a write in a reset cycle still completes.

Configuration
REQ-022 SHALL support macro WBUF_RAM_WR_BYPASS_EN; when defined, a same-cycle same-address read and write SHALL capture s_write_data (write-first); when undefined, REQ-017 applies.

Structure
REQ-023 SHALL put the default widths (ADDR_WIDTH 9, DATA_WIDTH 64) as constants in shared package wbuf_pkg.
REQ-024 SHALL implement the output pipeline stage with sub-module register_sync (parameter WIDTH; ports clk, reset, in, out; out<=in each cycle; out<=0 on reset).
REQ-025 SHALL use register_sync, WIDTH=1 and WIDTH=ADDR_WIDTH, as the reusable one-cycle delay cell for request/address forwarding by parent banked buffers.

Verification (ADDR_WIDTH=4, DATA_WIDTH=16, OUTPUT_REG=1 unless stated)
REQ-026 SHALL cover: write 0xBEEF@3, then read@3 at cycle t -> s_read_data=0xBEEF at t+2, previous value at t+1.
REQ-027 SHALL cover: OUTPUT_REG=0, write 0x1234@15, read@15 at t -> 0x1234 at t+1.
REQ-028 SHALL cover: write 0xAAAA@5, then at one cycle write 0x5555@5 and read@5 -> 0xAAAA without WBUF_RAM_WR_BYPASS_EN, 0x5555 with it.
REQ-029 SHALL cover: read 0xBEEF@3, then hold s_read_req=0 for 5 cycles -> s_read_data stays 0xBEEF.
REQ-030 SHALL cover: reset pulse after writing 0x0F0F@7 -> s_read_data=0 after reset; a later read@7 -> 0x0F0F.
REQ-031 SHALL cover: register_sync WIDTH=4, drive in=0x9 -> out=0x9 one cycle later; reset -> out=0.

Source files
------------

// File: rtl/wbuf_pkg.sv
// Shared constants for the write-buffer RAM family.
// Default geometry: 512 words of 64 bits.
package wbuf_pkg;

  localparam int unsigned WBUF_ADDR_WIDTH = 9;
  localparam int unsigned WBUF_DATA_WIDTH = 64;

  // Number of words addressed by an address of the given width.
  function automatic int unsigned wbuf_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/register_sync.sv
// One-cycle delay cell with synchronous active-high clear.
// Used as the RAM output pipeline stage and for request/address forwarding.
module register_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  // Free-running capture; reset forces zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      out <= '0;
    end else begin
      out <= in;
    end
  end

endmodule

// File: rtl/wbuf_ram.sv
// Simple dual-port RAM (one write port, one read port, single clock).
// Read latency is one cycle, or two with OUTPUT_REG=1.
// Optional macro WBUF_RAM_WR_BYPASS_EN: a same-cycle same-address read returns
// the incoming write data (write-first); otherwise the old contents (read-first).
// Memory contents are not cleared by reset; only the read/output registers are.
module wbuf_ram
  import wbuf_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = WBUF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = WBUF_DATA_WIDTH,
  parameter int unsigned OUTPUT_REG = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_write_req,
  input  logic [ADDR_WIDTH-1:0] s_write_addr,
  input  logic [DATA_WIDTH-1:0] s_write_data,
  input  logic                  s_read_req,
  input  logic [ADDR_WIDTH-1:0] s_read_addr,
  output logic [DATA_WIDTH-1:0] s_read_data
);

  localparam int unsigned Depth = wbuf_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [Depth];
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rd_q;

  // Write port; deliberately unaffected by reset so a write in a reset cycle lands.
  always_ff @(posedge clk) begin
    if (s_write_req) begin
      mem[s_write_addr] <= s_write_data;
    end
  end

  // Word selected for capture into the read register.
  always_comb begin
    rd_word = mem[s_read_addr];
`ifdef WBUF_RAM_WR_BYPASS_EN
    if (s_write_req && (s_write_addr == s_read_addr)) begin
      rd_word = s_write_data;
    end
`endif
  end

  // Read register: loads on request, holds otherwise, reset wins over a read.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q <= '0;
    end else if (s_read_req) begin
      rd_q <= rd_word;
    end
  end

  if (OUTPUT_REG != 0) begin : g_out_reg
    register_sync #(
      .WIDTH(DATA_WIDTH)
    ) u_out_reg (
      .clk  (clk),
      .reset(reset),
      .in   (rd_q),
      .out  (s_read_data)
    );
  end else begin : g_no_out_reg
    assign s_read_data = rd_q;
  end

endmodule

// File: tb/tb_wbuf_ram.sv
// Directed self-checking bench for wbuf_ram (both OUTPUT_REG settings)
// and the register_sync delay cell.
module tb_wbuf_ram;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;

  // Instance A: OUTPUT_REG=1
  logic          a_wr = 1'b0;
  logic [AW-1:0] a_waddr = '0;
  logic [DW-1:0] a_wdata = '0;
  logic          a_rd = 1'b0;
  logic [AW-1:0] a_raddr = '0;
  logic [DW-1:0] a_rdata;

  // Instance B: OUTPUT_REG=0
  logic          b_wr = 1'b0;
  logic [AW-1:0] b_waddr = '0;
  logic [DW-1:0] b_wdata = '0;
  logic          b_rd = 1'b0;
  logic [AW-1:0] b_raddr = '0;
  logic [DW-1:0] b_rdata;

  // Standalone delay cell
  logic [3:0]    rs_in = '0;
  logic [3:0]    rs_out;

  int unsigned   total = 0;
  int unsigned   passed = 0;
  logic [DW-1:0] exp_v;

  always #5 clk = ~clk;

  wbuf_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTPUT_REG(1)) u_dut_a (
    .clk         (clk),
    .reset       (reset),
    .s_write_req (a_wr),
    .s_write_addr(a_waddr),
    .s_write_data(a_wdata),
    .s_read_req  (a_rd),
    .s_read_addr (a_raddr),
    .s_read_data (a_rdata)
  );

  wbuf_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTPUT_REG(0)) u_dut_b (
    .clk         (clk),
    .reset       (reset),
    .s_write_req (b_wr),
    .s_write_addr(b_waddr),
    .s_write_data(b_wdata),
    .s_read_req  (b_rd),
    .s_read_addr (b_raddr),
    .s_read_data (b_rdata)
  );

  register_sync #(.WIDTH(4)) u_rs (
    .clk  (clk),
    .reset(reset),
    .in   (rs_in),
    .out  (rs_out)
  );

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  initial begin
    // Reset
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("reset_a", 32'(a_rdata), 32'h0);
    check("reset_b", 32'(b_rdata), 32'h0);
    check("reset_rs", 32'(rs_out), 32'h0);

    // register_sync: one-cycle delay
    rs_in = 4'h9;
    check("rs_before", 32'(rs_out), 32'h0);
    tick();
    check("rs_delay", 32'(rs_out), 32'h9);

    // Two-cycle read latency
    a_wr = 1'b1; a_waddr = 4'd3; a_wdata = 16'hBEEF;
    tick();
    a_wr = 1'b0;
    a_rd = 1'b1; a_raddr = 4'd3;
    tick();
    a_rd = 1'b0;
    check("lat2_t1", 32'(a_rdata), 32'h0);
    tick();
    check("lat2_t2", 32'(a_rdata), 32'hBEEF);

    // Hold with no read request
    a_raddr = 4'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold", 32'(a_rdata), 32'hBEEF);
    end

    // One-cycle latency on instance B
    b_wr = 1'b1; b_waddr = 4'd15; b_wdata = 16'h1234;
    tick();
    b_wr = 1'b0;
    b_rd = 1'b1; b_raddr = 4'd15;
    tick();
    b_rd = 1'b0;
    check("lat1", 32'(b_rdata), 32'h1234);

    // Same-cycle same-address read and write
    a_wr = 1'b1; a_waddr = 4'd5; a_wdata = 16'hAAAA;
    tick();
    a_wdata = 16'h5555;
    a_rd = 1'b1; a_raddr = 4'd5;
    tick();
    a_wr = 1'b0; a_rd = 1'b0;
    tick();
`ifdef WBUF_RAM_WR_BYPASS_EN
    exp_v = 16'h5555;
`else
    exp_v = 16'hAAAA;
`endif
    check("collide", 32'(a_rdata), 32'(exp_v));
    a_rd = 1'b1; a_raddr = 4'd5;
    tick();
    a_rd = 1'b0;
    tick();
    check("collide_wr_landed", 32'(a_rdata), 32'h5555);

    // Reset clears read path, keeps memory; write during reset lands, read is blocked
    a_wr = 1'b1; a_waddr = 4'd7; a_wdata = 16'h0F0F;
    tick();
    reset = 1'b1;
    a_waddr = 4'd8; a_wdata = 16'h1111;
    a_rd = 1'b1; a_raddr = 4'd3;
    tick();
    reset = 1'b0; a_wr = 1'b0; a_rd = 1'b0;
    check("rst_clear", 32'(a_rdata), 32'h0);
    check("rst_clear_b", 32'(b_rdata), 32'h0);
    check("rst_rs", 32'(rs_out), 32'h0);
    tick();
    check("rst_read_blocked", 32'(a_rdata), 32'h0);
    a_rd = 1'b1; a_raddr = 4'd7;
    tick();
    a_raddr = 4'd8;
    tick();
    a_rd = 1'b0;
    check("post_rst_7", 32'(a_rdata), 32'h0F0F);
    tick();
    check("rst_cycle_write", 32'(a_rdata), 32'h1111);

    // Concurrent read and write to different addresses
    a_wr = 1'b1; a_waddr = 4'd9; a_wdata = 16'h2222;
    a_rd = 1'b1; a_raddr = 4'd8;
    tick();
    a_wr = 1'b0; a_rd = 1'b0;
    tick();
    check("rw_diff", 32'(a_rdata), 32'h1111);

    // Every address holds a distinct word
    for (int i = 0; i < 16; i++) begin
      a_wr = 1'b1; a_waddr = AW'(i);
      a_wdata = 16'hC000 | 16'(i << 8) | 16'(15 - i);
      tick();
    end
    a_wr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      a_rd = 1'b1; a_raddr = AW'(i);
      tick();
      a_rd = 1'b0;
      tick();
      exp_v = 16'hC000 | 16'(i << 8) | 16'(15 - i);
      check("sweep", 32'(a_rdata), 32'(exp_v));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
